// File: rtl/time_date_setter_if.sv
// Front-panel editor bus: debounced buttons and keys, live time/date in,
// edit buffers, write strobes and field/blink status out.
interface time_date_setter_if;
  logic        btn_mode;
  logic        btn_cancel;
  logic        key_up;
  logic        key_down;
  logic [16:0] time_in;
  logic [20:0] date_in;
  logic [16:0] time_out;
  logic [20:0] date_out;
  logic        time_ow;
  logic        date_ow;
  logic [2:0]  edit_field;
  logic        blink;

  modport master (
    output btn_mode, btn_cancel, key_up, key_down, time_in, date_in,
    input  time_out, date_out, time_ow, date_ow, edit_field, blink
  );
  modport slave (
    input  btn_mode, btn_cancel, key_up, key_down, time_in, date_in,
    output time_out, date_out, time_ow, date_ow, edit_field, blink
  );
endinterface

// File: rtl/time_date_setter.sv
// Time/date field editor: snapshot live values, step fields with wrap and
// auto-repeat, then issue one-cycle overwrite strobes on commit.
module time_date_key_step #(
  parameter int REPEAT_DELAY  = 50_000_000,
  parameter int REPEAT_PERIOD = 10_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic key,
  input  logic block,
  output logic step,
  output logic key_edge
);
  logic        key_q, rep;
  logic [31:0] rcnt;
  logic        fire;

  assign fire     = key && key_q && !block &&
                    (rep ? (rcnt == 32'(REPEAT_PERIOD)) : (rcnt == 32'(REPEAT_DELAY)));
  assign step     = key && !block && (!key_q || fire);
  assign key_edge = key ^ key_q;

  // rcnt equals the number of cycles since the press (or since the last repeat step)
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      key_q <= 1'b0;
      rep   <= 1'b0;
      rcnt  <= '0;
    end else begin
      key_q <= key;
      if (!key || block) begin
        rcnt <= '0;
        rep  <= 1'b0;
      end else if (!key_q) begin
        rcnt <= 32'd1;
        rep  <= 1'b0;
      end else if (fire) begin
        rcnt <= 32'd1;
        rep  <= 1'b1;
      end else begin
        rcnt <= rcnt + 32'd1;
      end
    end
endmodule

module time_date_setter #(
  parameter int REPEAT_DELAY  = 50_000_000,
  parameter int REPEAT_PERIOD = 10_000_000,
  parameter int BLINK_HALF    = 25_000_000,
  parameter int TIMEOUT       = 1_500_000_000
) (
  input logic clk,
  input logic rst,
  time_date_setter_if.slave bus
);
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_HOUR = 3'd1, S_MIN = 3'd2, S_YEAR = 3'd3,
    S_MONTH = 3'd4, S_DAY = 3'd5, S_COMMIT = 3'd6
  } state_t;

  state_t      state, state_n;
  logic [4:0]  hh, hh_n, dd, dd_n, dmax, dd_c, day_in;
  logic [5:0]  mm, mm_n;
  logic [11:0] yr, yr_n;
  logic [3:0]  mo, mo_n, mo_c;
  logic [31:0] to_cnt, bcnt;
  logic        blink_q;
  logic        edit, to_hit, abort, do_step, up;
  logic [1:0]  keys, step, kedge;

  function automatic logic [4:0] dim_f(input logic [3:0] m, input logic [11:0] y);
    case (m)
      4'd4, 4'd6, 4'd9, 4'd11: dim_f = 5'd30;
      4'd2:                    dim_f = (y[1:0] == 2'b00) ? 5'd29 : 5'd28;
      default:                 dim_f = 5'd31;
    endcase
  endfunction

  assign keys = {bus.key_down, bus.key_up};

  for (genvar k = 0; k < 2; k++) begin : g_key
    time_date_key_step #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)) u_key (
      .clk(clk), .rst(rst), .key(keys[k]), .block(&keys),
      .step(step[k]), .key_edge(kedge[k])
    );
  end

  assign edit    = (state >= S_HOUR) && (state <= S_DAY);
  assign to_hit  = edit && (to_cnt == 32'(TIMEOUT - 1));
  assign abort   = edit && (bus.btn_cancel || to_hit);
  assign do_step = edit && !abort && !bus.btn_mode && (|step);
  assign up      = step[0];

  // Snapshot clamp: out-of-range fields fall back to their minimum
  assign day_in = bus.date_in[20:16];
  assign mo_c   = (bus.date_in[15:12] == 4'd0 || bus.date_in[15:12] > 4'd12) ? 4'd1 : bus.date_in[15:12];
  assign dd_c   = (day_in == 5'd0 || day_in > dim_f(mo_c, bus.date_in[11:0])) ? 5'd1 : day_in;

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:   if (bus.btn_mode) state_n = S_HOUR;
      S_COMMIT: state_n = S_IDLE;
      default:
        if (abort) state_n = S_IDLE;
        else if (bus.btn_mode) state_n = (state == S_DAY) ? S_COMMIT : state_t'(state + 3'd1);
    endcase
  end

  always_comb begin
    hh_n = hh; mm_n = mm; yr_n = yr; mo_n = mo; dd_n = dd;
    dmax = dim_f(mo, yr);
    if (state == S_IDLE && bus.btn_mode) begin
      hh_n = (bus.time_in[16:12] > 5'd23) ? 5'd0 : bus.time_in[16:12];
      mm_n = (bus.time_in[11:6] > 6'd59) ? 6'd0 : bus.time_in[11:6];
      yr_n = bus.date_in[11:0];
      mo_n = mo_c;
      dd_n = dd_c;
    end else if (do_step) begin
      case (state)
        S_HOUR: hh_n = up ? ((hh >= 5'd23) ? 5'd0 : hh + 5'd1) : ((hh == 5'd0) ? 5'd23 : hh - 5'd1);
        S_MIN:  mm_n = up ? ((mm >= 6'd59) ? 6'd0 : mm + 6'd1) : ((mm == 6'd0) ? 6'd59 : mm - 6'd1);
        S_YEAR: yr_n = up ? yr + 12'd1 : yr - 12'd1;
        S_MONTH: mo_n = up ? ((mo >= 4'd12) ? 4'd1 : mo + 4'd1) : ((mo <= 4'd1) ? 4'd12 : mo - 4'd1);
        S_DAY:  dd_n = up ? ((dd >= dmax) ? 5'd1 : dd + 5'd1) : ((dd <= 5'd1) ? dmax : dd - 5'd1);
        default: ;
      endcase
      // Month/year changes pull the day back inside the new month
      if (state == S_YEAR || state == S_MONTH) begin
        dmax = dim_f(mo_n, yr_n);
        if (dd > dmax) dd_n = dmax;
      end
    end
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state   <= S_IDLE;
      hh      <= '0;
      mm      <= '0;
      yr      <= '0;
      mo      <= 4'd1;
      dd      <= 5'd1;
      to_cnt  <= '0;
      bcnt    <= '0;
      blink_q <= 1'b0;
    end else begin
      state <= state_n;
      hh <= hh_n; mm <= mm_n; yr <= yr_n; mo <= mo_n; dd <= dd_n;
      if (!edit || bus.btn_mode || (|step) || (|kedge)) to_cnt <= '0;
      else to_cnt <= to_cnt + 32'd1;
      if (!edit || state_n != state) begin
        bcnt    <= '0;
        blink_q <= 1'b0;
      end else if (bcnt == 32'(BLINK_HALF - 1)) begin
        bcnt    <= '0;
        blink_q <= ~blink_q;
      end else begin
        bcnt <= bcnt + 32'd1;
      end
    end

  assign bus.time_out   = {hh, mm, 6'd0};
  assign bus.date_out   = {dd, mo, yr};
  assign bus.time_ow    = (state == S_COMMIT);
  assign bus.date_ow    = (state == S_COMMIT);
  assign bus.edit_field = (state == S_COMMIT) ? 3'd0 : state;
  assign bus.blink      = blink_q;
endmodule

// File: tb/tb_time_date_setter.sv
// Directed bench for time_date_setter with shortened timing parameters.
module tb_time_date_setter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;
  int   ow_cnt = 0;

  time_date_setter_if tif();

  time_date_setter #(.REPEAT_DELAY(8), .REPEAT_PERIOD(3), .BLINK_HALF(4), .TIMEOUT(64)) dut (
    .clk(clk), .rst(rst), .bus(tif)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (tif.time_ow) ow_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse_mode();
    tif.btn_mode = 1'b1; cyc(1); tif.btn_mode = 1'b0;
  endtask

  task automatic press(input bit is_up);
    if (is_up) tif.key_up = 1'b1; else tif.key_down = 1'b1;
    cyc(1);
    tif.key_up = 1'b0; tif.key_down = 1'b0;
    cyc(1);
  endtask

  task automatic enter(input logic [16:0] t, input logic [20:0] d);
    tif.time_in = t; tif.date_in = d; pulse_mode();
  endtask

  task automatic cancel();
    tif.btn_cancel = 1'b1; cyc(1); tif.btn_cancel = 1'b0;
  endtask

  initial begin
    tif.btn_mode = 0; tif.btn_cancel = 0; tif.key_up = 0; tif.key_down = 0;
    tif.time_in = '0; tif.date_in = '0;
    cyc(3);
    check("rst_time", tif.time_out, 0);
    check("rst_date", tif.date_out, {5'd1, 4'd1, 12'd0});
    check("rst_ow", {tif.time_ow, tif.date_ow}, 0);
    check("rst_field", tif.edit_field, 0);
    check("rst_blink", tif.blink, 0);
    rst = 1'b1; cyc(1);

    // blink timing and clearing on field change
    enter({5'd1, 6'd2, 6'd3}, {5'd5, 4'd6, 12'd7});
    cyc(3);
    check("blink_lo", tif.blink, 0);
    cyc(1);
    check("blink_hi", tif.blink, 1);
    pulse_mode();
    check("blink_clr", tif.blink, 0);
    cancel();
    check("blink_idle", tif.blink, 0);

    // T1 full edit with commit
    enter({5'd23, 6'd59, 6'd17}, {5'd31, 4'd12, 12'd2023});
    check("t1_field_hour", tif.edit_field, 1);
    check("t1_capture", tif.time_out, {5'd23, 6'd59, 6'd0});
    press(1);
    check("t1_hour_wrap", tif.time_out[16:12], 0);
    pulse_mode(); press(1);
    check("t1_min_wrap", tif.time_out, 0);
    pulse_mode(); press(1);
    pulse_mode(); pulse_mode();
    check("t1_field_day", tif.edit_field, 5);
    tif.btn_mode = 1'b1; cyc(1); tif.btn_mode = 1'b0;
    check("t1_ow", {tif.time_ow, tif.date_ow}, 2'b11);
    check("t1_commit_field", tif.edit_field, 0);
    check("t1_date", tif.date_out, {5'd31, 4'd12, 12'd2024});
    cyc(1);
    check("t1_ow_off", {tif.time_ow, tif.date_ow}, 0);
    check("t1_hold", tif.date_out, {5'd31, 4'd12, 12'd2024});
    check("t1_ow_count", ow_cnt, 1);

    // T2 down wrap, then cancel keeps buffers
    enter({5'd0, 6'd30, 6'd0}, {5'd1, 4'd1, 12'd0});
    press(0);
    check("t2_hour", tif.time_out[16:12], 23);
    pulse_mode(); pulse_mode(); press(0);
    check("t2_year", tif.date_out[11:0], 4095);
    pulse_mode(); press(0);
    check("t2_month", tif.date_out[15:12], 12);
    cancel();
    check("t2_cancel_field", tif.edit_field, 0);
    check("t2_cancel_keep", tif.date_out, {5'd1, 4'd12, 12'd4095});
    check("t2_no_strobe", ow_cnt, 1);

    // T3 day clamp on month/year change
    enter({5'd1, 6'd1, 6'd0}, {5'd31, 4'd1, 12'd2023});
    pulse_mode(); pulse_mode(); pulse_mode(); press(1);
    check("t3_feb2023", tif.date_out, {5'd28, 4'd2, 12'd2023});
    cancel();
    enter({5'd1, 6'd1, 6'd0}, {5'd31, 4'd1, 12'd2024});
    pulse_mode(); pulse_mode(); pulse_mode(); press(1);
    check("t3_feb2024", tif.date_out, {5'd29, 4'd2, 12'd2024});
    cancel();
    enter({5'd1, 6'd1, 6'd0}, {5'd29, 4'd2, 12'd2024});
    pulse_mode(); pulse_mode(); press(0);
    check("t3_year_down", tif.date_out, {5'd28, 4'd2, 12'd2023});
    cancel();
    // out-of-range snapshot clamps to minimums
    enter({5'd30, 6'd61, 6'd0}, {5'd0, 4'd13, 12'd9});
    check("t3_clamp_time", tif.time_out, 0);
    check("t3_clamp_date", tif.date_out, {5'd1, 4'd1, 12'd9});
    cancel();

    // T4 auto-repeat in MIN
    enter({5'd1, 6'd10, 6'd0}, {5'd1, 4'd1, 12'd0});
    pulse_mode();
    tif.key_up = 1'b1;
    cyc(8);
    check("t4_before_rep", tif.time_out[11:6], 11);
    cyc(12);
    tif.key_up = 1'b0;
    check("t4_repeat", tif.time_out[11:6], 15);
    cyc(1);
    tif.key_up = 1'b1; tif.key_down = 1'b1;
    cyc(20);
    tif.key_up = 1'b0; tif.key_down = 1'b0;
    cyc(1);
    check("t4_both", tif.time_out[11:6], 15);
    press(0);
    check("t4_down", tif.time_out[11:6], 14);
    cancel();

    // T5 abort paths
    enter({5'd1, 6'd1, 6'd0}, {5'd1, 4'd1, 12'd0});
    pulse_mode(); pulse_mode(); pulse_mode();
    check("t5_in_month", tif.edit_field, 4);
    cancel();
    check("t5_cancel", tif.edit_field, 0);
    enter({5'd1, 6'd1, 6'd0}, {5'd1, 4'd1, 12'd0});
    cyc(62);
    check("t5_pre_timeout", tif.edit_field, 1);
    cyc(4);
    check("t5_timeout", tif.edit_field, 0);
    enter({5'd1, 6'd1, 6'd0}, {5'd1, 4'd1, 12'd0});
    tif.btn_mode = 1'b1; tif.btn_cancel = 1'b1; cyc(1);
    tif.btn_mode = 1'b0; tif.btn_cancel = 1'b0;
    check("t5_cancel_mode", tif.edit_field, 0);
    check("t5_no_strobe", ow_cnt, 1);

    // T6 reset during the commit cycle
    enter({5'd5, 6'd6, 6'd0}, {5'd7, 4'd8, 12'd9});
    pulse_mode(); pulse_mode(); pulse_mode(); pulse_mode();
    tif.btn_mode = 1'b1; cyc(1); tif.btn_mode = 1'b0;
    check("t6_commit", tif.time_ow, 1);
    rst = 1'b0; #1;
    check("t6_ow", {tif.time_ow, tif.date_ow}, 0);
    check("t6_field", tif.edit_field, 0);
    check("t6_time", tif.time_out, 0);
    check("t6_date", tif.date_out, {5'd1, 4'd1, 12'd0});
    cyc(2);
    rst = 1'b1;
    cyc(2);
    check("t6_ow_count", ow_cnt, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
